// File: rtl/mem_access.sv
// Memory stage: issues the EX/MEM load/store on a req/ready data-memory port,
// aligns and extends load data, and registers the results for write-back.
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       store_data,
    input  logic              ctr_mem_read,
    input  logic              ctr_mem_write,
    input  logic [1:0]        ctr_size,
    input  logic              ctr_unsigned,
    input  logic              ctr_mem_to_reg_in,
    input  logic              ctr_reg_write_in,
    input  logic [4:0]        dest_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       datamem,
    output logic [31:0]       alu,
    output logic              ctr_mem_to_reg,
    output logic              ctr_reg_write,
    output logic [4:0]        dest,
    output logic              out_valid,
    output logic              misalign,
    output logic              bus_err,
    output logic              dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Copy of the instruction taken in IDLE, replayed while waiting.
    logic        lat_rd, lat_wr, lat_uns, lat_mtr, lat_rw;
    logic [1:0]  lat_size;
    logic [31:0] lat_alu, lat_sd;
    logic [4:0]  lat_dest;

    logic        cur_valid, cur_rd, cur_wr, cur_uns, cur_mtr, cur_rw;
    logic [1:0]  cur_size, off;
    logic [31:0] cur_alu, cur_sd;
    logic [4:0]  cur_dest;

    logic        access_c, misal_c, is_load_c;
    logic        req_c, load_en, misal_ev, bus_ev;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, shifted, ld_val, dm_next;

    always_comb begin
        if (state_q == WAIT) begin
            cur_valid = 1'b1;
            cur_rd    = lat_rd;
            cur_wr    = lat_wr;
            cur_uns   = lat_uns;
            cur_mtr   = lat_mtr;
            cur_rw    = lat_rw;
            cur_size  = lat_size;
            cur_alu   = lat_alu;
            cur_sd    = lat_sd;
            cur_dest  = lat_dest;
        end else begin
            cur_valid = in_valid;
            cur_rd    = ctr_mem_read;
            cur_wr    = ctr_mem_write;
            cur_uns   = ctr_unsigned;
            cur_mtr   = ctr_mem_to_reg_in;
            cur_rw    = ctr_reg_write_in;
            cur_size  = ctr_size;
            cur_alu   = alu_in;
            cur_sd    = store_data;
            cur_dest  = dest_in;
        end
    end

    assign off       = cur_alu[1:0];
    assign access_c  = cur_valid && (cur_rd || cur_wr);
    assign is_load_c = cur_valid && cur_rd && !cur_wr;
    assign misal_c   = ((cur_size == 2'b01) && cur_alu[0]) ||
                       (cur_size[1] && (cur_alu[1:0] != 2'b00));

    // Store lanes are little-endian; loads always fetch the whole word.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = cur_sd;
        if (cur_wr) begin
            case (cur_size)
                2'b00: begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{cur_sd[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << off;
                    wdata_c = {2{cur_sd[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign shifted = dmem_rdata >> {off, 3'b000};

    always_comb begin
        case (cur_size)
            2'b00:   ld_val = cur_uns ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_val = cur_uns ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_val = dmem_rdata;
        endcase
    end

    // Handshake: dmem_req stays high with addr/we/be/wdata stable until the
    // cycle dmem_ready is seen with it (the transfer) or the wait times out;
    // dmem_ready with dmem_req low carries no meaning and is ignored.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        req_c    = 1'b0;
        load_en  = 1'b0;
        misal_ev = 1'b0;
        bus_ev   = 1'b0;
        case (state_q)
            IDLE: begin
                load_en = 1'b1;
                if (access_c) begin
                    if (misal_c) begin
                        misal_ev = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (!dmem_ready) begin
                            stall   = 1'b1;
                            load_en = 1'b0;
                            state_d = WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    bus_ev  = 1'b1;
                    load_en = 1'b1;
                    state_d = IDLE;
                end else begin
                    req_c = 1'b1;
                    if (dmem_ready) begin
                        load_en = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            stall = 1'b0;
            req_c = 1'b0;
        end
    end

    assign dmem_req   = req_c;
    assign dmem_we    = req_c & cur_wr;
    assign dmem_addr  = req_c ? {cur_alu[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be    = req_c ? be_c : 4'b0000;
    assign dmem_wdata = req_c ? wdata_c : 32'h0;
    assign dm_next    = (is_load_c && !misal_ev && !bus_ev) ? ld_val : 32'h0;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_uns  <= 1'b0;
            lat_mtr  <= 1'b0;
            lat_rw   <= 1'b0;
            lat_size <= 2'b00;
            lat_alu  <= 32'h0;
            lat_sd   <= 32'h0;
            lat_dest <= 5'd0;
        end else if (state_q == IDLE) begin
            lat_rd   <= ctr_mem_read;
            lat_wr   <= ctr_mem_write;
            lat_uns  <= ctr_unsigned;
            lat_mtr  <= ctr_mem_to_reg_in;
            lat_rw   <= ctr_reg_write_in;
            lat_size <= ctr_size;
            lat_alu  <= alu_in;
            lat_sd   <= store_data;
            lat_dest <= dest_in;
        end
    end

    // Stage register: holds through stalls, with out_valid and pulses cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            datamem        <= 32'h0;
            alu            <= 32'h0;
            ctr_mem_to_reg <= 1'b0;
            ctr_reg_write  <= 1'b0;
            dest           <= 5'd0;
            out_valid      <= 1'b0;
            misalign       <= 1'b0;
            bus_err        <= 1'b0;
        end else if (load_en) begin
            datamem        <= dm_next;
            alu            <= cur_alu;
            ctr_mem_to_reg <= cur_mtr;
            ctr_reg_write  <= cur_valid && cur_rw && !misal_ev && !bus_ev;
            dest           <= cur_dest;
            out_valid      <= cur_valid;
            misalign       <= misal_ev;
            bus_err        <= bus_ev;
        end else begin
            out_valid      <= 1'b0;
            misalign       <= 1'b0;
            bus_err        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed and short random bench for mem_access, with a scoreboard of
// expected write-back records compared whenever out_valid is seen.
module tb_mem_access;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_in, store_data;
    logic        ctr_mem_read, ctr_mem_write;
    logic [1:0]  ctr_size;
    logic        ctr_unsigned, ctr_mem_to_reg_in, ctr_reg_write_in;
    logic [4:0]  dest_in;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] datamem, alu;
    logic        ctr_mem_to_reg, ctr_reg_write;
    logic [4:0]  dest;
    logic        out_valid, misalign, bus_err, dbg_state;

    int total = 0;
    int bad   = 0;
    logic [72:0] exp_q[$];

    mem_access #(.ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_in(alu_in),
        .store_data(store_data), .ctr_mem_read(ctr_mem_read),
        .ctr_mem_write(ctr_mem_write), .ctr_size(ctr_size),
        .ctr_unsigned(ctr_unsigned), .ctr_mem_to_reg_in(ctr_mem_to_reg_in),
        .ctr_reg_write_in(ctr_reg_write_in), .dest_in(dest_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .datamem(datamem), .alu(alu), .ctr_mem_to_reg(ctr_mem_to_reg),
        .ctr_reg_write(ctr_reg_write), .dest(dest), .out_valid(out_valid),
        .misalign(misalign), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected write-back record: {datamem, alu, mem_to_reg, reg_write, dest, misalign, bus_err}
    function automatic logic [72:0] model(input logic rd, input logic wr,
                                          input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rdata,
                                          input logic mtr, input logic rw,
                                          input logic [4:0] dst, input logic tmo);
        logic        mis;
        logic [31:0] dm;
        logic [7:0]  b;
        logic [15:0] h;
        int          o;
        o   = int'(addr[1:0]);
        mis = (rd || wr) && (((size == 2'b01) && addr[0]) ||
                             ((size >= 2'b10) && (addr[1:0] != 2'b00)));
        dm  = 32'h0;
        if (rd && !wr && !mis && !tmo) begin
            case (size)
                2'b00: begin
                    b  = rdata[8*o +: 8];
                    dm = uns ? {24'h0, b} : {{24{b[7]}}, b};
                end
                2'b01: begin
                    h  = (o == 2) ? rdata[31:16] : rdata[15:0];
                    dm = uns ? {16'h0, h} : {{16{h[15]}}, h};
                end
                default: dm = rdata;
            endcase
        end
        return {dm, addr, mtr, rw && !mis && !tmo, dst, mis, tmo};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic mtr, input logic rw, input logic [4:0] dst);
        in_valid          = v;
        ctr_mem_read      = rd;
        ctr_mem_write     = wr;
        ctr_size          = size;
        ctr_unsigned      = uns;
        alu_in            = a;
        store_data        = sd;
        ctr_mem_to_reg_in = mtr;
        ctr_reg_write_in  = rw;
        dest_in           = dst;
    endtask

    task automatic bubble();
        in_valid      = 1'b0;
        ctr_mem_read  = 1'b0;
        ctr_mem_write = 1'b0;
        dmem_ready    = 1'b0;
    endtask

    // scoreboard
    always @(negedge clk) begin
        logic [72:0] e, obs;
        if (reset === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out_valid", {31'h0, out_valid}, 32'h0);
            end else begin
                e   = exp_q.pop_front();
                obs = {datamem, alu, ctr_mem_to_reg, ctr_reg_write, dest, misalign, bus_err};
                total++;
                assert (obs === e) else begin
                    bad++;
                    $error("FAIL sb_record observed=0x%019h expected=0x%019h", obs, e);
                end
            end
        end
    end

    initial begin
        int          n;
        logic [1:0]  rs;
        logic        rw_r, ru;
        logic [31:0] ra, rd_word, rsd;
        int          lat;

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_datamem", datamem, 32'h0);
        chk("rst_state", {31'h0, dbg_state}, 32'h0);
        step();
        reset = 1'b1;

        // lb at 0x1003, ready in the same cycle
        drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 1'b1, 1'b1, 5'd3);
        dmem_rdata = 32'h80FF_FF12;
        dmem_ready = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h80FF_FF12, 1'b1, 1'b1, 5'd3, 1'b0));
        @(negedge clk);
        chk("lb_stall", {31'h0, stall}, 32'h0);
        chk("lb_req", {31'h0, dmem_req}, 32'h1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_be", {28'h0, dmem_be}, 32'hF);
        step();
        bubble();
        @(negedge clk);
        chk("lb_out_valid", {31'h0, out_valid}, 32'h1);
        chk("lb_datamem", datamem, 32'hFFFF_FF80);
        chk("lb_alu", alu, 32'h1003);

        // sh at 0x2002, three stalled cycles then ready
        step();
        drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 1'b0, 1'b0, 5'd0);
        dmem_ready = 1'b0;
        exp_q.push_back(model(1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0));
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n += int'(stall);
            chk("sh_req", {31'h0, dmem_req}, 32'h1);
            chk("sh_we", {31'h0, dmem_we}, 32'h1);
            chk("sh_be", {28'h0, dmem_be}, 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            chk("sh_addr", dmem_addr, 32'h2000);
            chk("sh_out_valid_low", {31'h0, out_valid}, 32'h0);
            step();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("sh_stall_cycles", 32'(n), 32'd3);
        chk("sh_stall_drop", {31'h0, stall}, 32'h0);
        step();
        bubble();
        @(negedge clk);
        chk("sh_out_valid", {31'h0, out_valid}, 32'h1);
        chk("sh_datamem", datamem, 32'h0);

        // lhu then lh at 0x0002, back to back
        step();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0002, 32'h0, 1'b1, 1'b1, 5'd5);
        dmem_rdata = 32'hF00D_0000;
        dmem_ready = 1'b1;
        exp_q.push_back(model(1'b1, 1'b0, 2'b01, 1'b1, 32'h0002, 32'hF00D_0000, 1'b1, 1'b1, 5'd5, 1'b0));
        @(negedge clk);
        chk("lhu_stall", {31'h0, stall}, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0002, 32'h0, 1'b1, 1'b1, 5'd6);
        exp_q.push_back(model(1'b1, 1'b0, 2'b01, 1'b0, 32'h0002, 32'hF00D_0000, 1'b1, 1'b1, 5'd6, 1'b0));
        @(negedge clk);
        chk("lhu_datamem", datamem, 32'h0000_F00D);
        step();
        bubble();
        @(negedge clk);
        chk("lh_datamem", datamem, 32'hFFFF_F00D);

        // misaligned lw at 0x0006
        step();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0006, 32'h0, 1'b1, 1'b1, 5'd9);
        exp_q.push_back(model(1'b1, 1'b0, 2'b10, 1'b0, 32'h0006, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0));
        @(negedge clk);
        chk("mis_req", {31'h0, dmem_req}, 32'h0);
        chk("mis_stall", {31'h0, stall}, 32'h0);
        step();
        bubble();
        @(negedge clk);
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_reg_write", {31'h0, ctr_reg_write}, 32'h0);
        chk("mis_out_valid", {31'h0, out_valid}, 32'h1);
        step();
        @(negedge clk);
        chk("mis_pulse_end", {31'h0, misalign}, 32'h0);

        // load that never gets ready: timeout then a late ready
        step();
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0100, 32'h0, 1'b1, 1'b1, 5'd10);
        exp_q.push_back(model(1'b1, 1'b0, 2'b10, 1'b0, 32'h0100, 32'h0, 1'b1, 1'b1, 5'd10, 1'b1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            step();
        end
        chk("tmo_stall_cycles", 32'(n), 32'd15);
        chk("tmo_req_dropped", {31'h0, dmem_req}, 32'h0);
        step();
        bubble();
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("tmo_bus_err", {31'h0, bus_err}, 32'h1);
        chk("tmo_reg_write", {31'h0, ctr_reg_write}, 32'h0);
        chk("tmo_out_valid", {31'h0, out_valid}, 32'h1);
        chk("tmo_state_idle", {31'h0, dbg_state}, 32'h0);
        step();
        @(negedge clk);
        chk("late_ready_out_valid", {31'h0, out_valid}, 32'h0);
        chk("late_ready_bus_err", {31'h0, bus_err}, 32'h0);
        chk("late_ready_stall", {31'h0, stall}, 32'h0);

        // reset asserted on the second WAIT cycle
        step();
        dmem_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0300, 32'h0, 1'b1, 1'b1, 5'd11);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall", {31'h0, stall}, 32'h0);
        chk("arst_req", {31'h0, dmem_req}, 32'h0);
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_alu", alu, 32'h0);
        chk("arst_dest", {27'h0, dest}, 32'h0);
        chk("arst_mem_to_reg", {31'h0, ctr_mem_to_reg}, 32'h0);
        chk("arst_state", {31'h0, dbg_state}, 32'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 5'd12);
        exp_q.push_back(model(1'b0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 5'd12, 1'b0));
        @(negedge clk);
        chk("alu_only_stall", {31'h0, stall}, 32'h0);
        chk("alu_only_req", {31'h0, dmem_req}, 32'h0);
        step();
        bubble();
        @(negedge clk);
        chk("alu_only_out_valid", {31'h0, out_valid}, 32'h1);
        chk("alu_only_alu", alu, 32'hDEAD_BEEF);

        // random aligned loads/stores with short random latency
        for (int k = 0; k < 12; k++) begin
            step();
            rs      = 2'($urandom_range(0, 2));
            rw_r    = 1'($urandom_range(0, 1));
            ru      = 1'($urandom_range(0, 1));
            lat     = int'($urandom_range(0, 3));
            rd_word = $urandom;
            rsd     = $urandom;
            ra      = $urandom & 32'hFFFF_FFFC;
            if (rs == 2'b00) ra[1:0] = 2'($urandom_range(0, 3));
            if (rs == 2'b01) ra[1]   = 1'($urandom_range(0, 1));
            drive(1'b1, !rw_r, rw_r, rs, ru, ra, rsd, !rw_r, !rw_r, 5'(k + 1));
            dmem_rdata = rd_word;
            dmem_ready = (lat == 0);
            exp_q.push_back(model(!rw_r, rw_r, rs, ru, ra, rd_word, !rw_r, !rw_r, 5'(k + 1), 1'b0));
            for (int j = 0; j < lat; j++) begin
                step();
                if (j == lat - 1) dmem_ready = 1'b1;
            end
        end
        step();
        bubble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
